// File: rtl/exp_arbiter_q824.sv
// Round-robin sequencer that time-shares one combinational Q8.24 exp unit among
// N_REQ requesters, with a per-requester response register and valid/ready handshake.

module exp_taylor_q824 (
   input  logic signed [31:0] x,
   output logic signed [31:0] y
);
   localparam logic signed [63:0] INV_LN2_Q30 = 64'sd1549082005;
   localparam logic signed [63:0] LN2_Q30     = 64'sd744261118;

   function automatic logic signed [63:0] coef(input int n);
      case (n)
         0:       coef = 64'sd1073741824;
         1:       coef = 64'sd1073741824;
         2:       coef = 64'sd536870912;
         3:       coef = 64'sd178956971;
         4:       coef = 64'sd44739243;
         5:       coef = 64'sd8947849;
         6:       coef = 64'sd1491308;
         7:       coef = 64'sd213044;
         8:       coef = 64'sd26631;
         9:       coef = 64'sd2959;
         default: coef = 64'sd0;
      endcase
   endfunction

   function automatic logic signed [63:0] rnd_shr(input logic signed [63:0] v, input int sh);
      logic signed [63:0] half;
      half    = 64'sd1 <<< (sh - 1);
      rnd_shr = (v + half) >>> sh;
   endfunction

   function automatic logic signed [31:0] sat_q824(input logic signed [63:0] v);
      if (v > 64'sh0000_0000_7FFF_FFFF)
         sat_q824 = 32'sh7FFF_FFFF;
      else if (v < 64'sd0)
         sat_q824 = 32'sd0;
      else
         sat_q824 = v[31:0];
   endfunction

   logic signed [63:0] x_w;
   logic signed [63:0] prod;
   logic signed [63:0] k_w;
   logic signed [63:0] r_q30;
   logic signed [63:0] p_q30;
   int                 sh;

   // x = k*ln2 + r with r in [0, ln2); e^r by Horner in Q2.30, then scaled by 2^k
   always_comb begin
      x_w   = {{32{x[31]}}, x};
      prod  = x_w * INV_LN2_Q30;
      k_w   = prod >>> 54;
      r_q30 = (x_w <<< 6) - k_w * LN2_Q30;
      p_q30 = coef(9);
      for (int n = 8; n >= 0; n--) begin
         p_q30 = coef(n) + ((p_q30 * r_q30) >>> 30);
      end
      sh = 6 - int'(k_w);
      if (sh >= 40)
         y = 32'sd0;
      else if (sh > 0)
         y = sat_q824(rnd_shr(p_q30, sh));
      else if (sh < -16)
         y = 32'sh7FFF_FFFF;
      else
         y = sat_q824(p_q30 <<< (-sh));
   end
endmodule

module exp_arbiter_q824 #(
   parameter int                 N_REQ = 4,
   parameter logic signed [31:0] X_MAX = 32'sd81401000,
   parameter logic signed [31:0] X_MIN = -32'sd268435456
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [32*N_REQ-1:0]   req_x,
   output logic [N_REQ-1:0]      req_ready,
   output logic [N_REQ-1:0]      rsp_valid,
   output logic [32*N_REQ-1:0]   rsp_y,
   output logic [N_REQ-1:0]      rsp_sat,
   input  logic [N_REQ-1:0]      rsp_ready,
   output logic                  busy
);
   localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]   pending_q, pending_d;
   logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
   logic [N_REQ-1:0]   rsp_sat_q, rsp_sat_d;
   logic [31:0]        rsp_y_q [N_REQ];
   logic [31:0]        rsp_y_d [N_REQ];
   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic               s1_valid_q, s1_valid_d;
   logic [ID_W-1:0]    s1_id_q, s1_id_d;
   logic signed [31:0] s1_x_q, s1_x_d;
   logic               s1_hi_q, s1_hi_d;
   logic               s1_lo_q, s1_lo_d;

   logic [31:0]        req_x_a [N_REQ];
   logic [N_REQ-1:0]   elig;
   logic [N_REQ-1:0]   hs;
   logic               gnt_vld;
   logic [ID_W-1:0]    gnt_id;
   logic signed [31:0] gnt_x;
   logic signed [31:0] exp_x;
   logic signed [31:0] exp_y;

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_pack
      assign req_x_a[gi]          = req_x[32*gi +: 32];
      assign rsp_y[32*gi +: 32]   = rsp_y_q[gi];
   end

   assign elig      = req_valid & ~pending_q;
   assign hs        = rsp_valid_q & rsp_ready;
   assign gnt_x     = $signed(req_x_a[gnt_id]);
   assign exp_x     = (s1_hi_q | s1_lo_q) ? 32'sd0 : s1_x_q;
   assign req_ready = ~pending_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_sat   = rsp_sat_q;
   assign busy      = |pending_q;

   exp_taylor_q824 u_exp (
      .x (exp_x),
      .y (exp_y)
   );

   always_comb begin
      int          idx;
      logic [ID_W-1:0] cand;
      gnt_vld = 1'b0;
      gnt_id  = '0;
      idx     = 0;
      cand    = '0;
      for (int off = 0; off < N_REQ; off++) begin
         idx = int'(ptr_q) + off;
         if (idx >= N_REQ) idx = idx - N_REQ;
         cand = ID_W'(idx);
         if (!gnt_vld && elig[cand]) begin
            gnt_vld = 1'b1;
            gnt_id  = cand;
         end
      end
   end

   always_comb begin
      s1_valid_d  = gnt_vld;
      s1_id_d     = s1_id_q;
      s1_x_d      = s1_x_q;
      s1_hi_d     = s1_hi_q;
      s1_lo_d     = s1_lo_q;
      pending_d   = pending_q & ~hs;
      ptr_d       = ptr_q;
      rsp_valid_d = rsp_valid_q & ~hs;
      rsp_sat_d   = rsp_sat_q;
      rsp_y_d     = rsp_y_q;
      if (gnt_vld) begin
         s1_id_d           = gnt_id;
         s1_x_d            = gnt_x;
         s1_hi_d           = gnt_x > X_MAX;
         s1_lo_d           = gnt_x < X_MIN;
         pending_d[gnt_id] = 1'b1;
         ptr_d             = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
      end
      // The slot of s1_id is reserved by pending, so this write never collides with a held result
      if (s1_valid_q) begin
         rsp_valid_d[s1_id_q] = 1'b1;
         rsp_sat_d[s1_id_q]   = s1_hi_q;
         if (s1_hi_q)
            rsp_y_d[s1_id_q] = 32'h7FFF_FFFF;
         else if (s1_lo_q)
            rsp_y_d[s1_id_q] = 32'h0000_0000;
         else
            rsp_y_d[s1_id_q] = exp_y;
      end
   end

   // Stage 1 control and stage 2 response registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q   <= '0;
         rsp_valid_q <= '0;
         rsp_sat_q   <= '0;
         ptr_q       <= '0;
         s1_valid_q  <= 1'b0;
         for (int i = 0; i < N_REQ; i++) rsp_y_q[i] <= '0;
      end else begin
         pending_q   <= pending_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_sat_q   <= rsp_sat_d;
         ptr_q       <= ptr_d;
         s1_valid_q  <= s1_valid_d;
         rsp_y_q     <= rsp_y_d;
      end
   end

   // Stage 1 operand registers, qualified by s1_valid_q
   always_ff @(posedge clk) begin
      s1_id_q <= s1_id_d;
      s1_x_q  <= s1_x_d;
      s1_hi_q <= s1_hi_d;
      s1_lo_q <= s1_lo_d;
   end
endmodule

// File: tb/tb_exp_arbiter_q824.sv
// Randomized scoreboard bench for exp_arbiter_q824 with a round-robin reference model
// and real-valued exp reference.

module tb_exp_arbiter_q824;
   localparam int                 N    = 4;
   localparam logic signed [31:0] XMAX = 32'sd81401000;
   localparam logic signed [31:0] XMIN = -32'sd268435456;
   localparam int                 TOL  = 2000;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [N-1:0]       req_valid = '0;
   logic [32*N-1:0]    req_x = '0;
   logic [N-1:0]       req_ready;
   logic [N-1:0]       rsp_valid;
   logic [32*N-1:0]    rsp_y;
   logic [N-1:0]       rsp_sat;
   logic [N-1:0]       rsp_ready = '0;
   logic               busy;

   exp_arbiter_q824 #(.N_REQ(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_x     (req_x),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_y     (rsp_y),
      .rsp_sat   (rsp_sat),
      .rsp_ready (rsp_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int                 id;
      logic signed [31:0] y;
      logic               s;
      int                 tol;
      int                 due;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   failures = 0;

   logic [N-1:0]       pend_m = '0;
   logic [N-1:0]       rspv_m = '0;
   int                 ptr_m = 0;
   logic               infl_v = 1'b0;
   int                 infl_id = 0;
   logic [N-1:0]       want = '0;
   logic [N-1:0]       persist = '0;
   logic signed [31:0] wx [N];

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chk_tol(input string nm, input longint act, input longint exp, input longint tol);
      longint d;
      d = act - exp;
      if (d < 0) d = -d;
      checks++;
      if (d > tol) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d +/- %0d (cycle %0d)", nm, act, exp, tol, cyc);
      end
   endtask

   function automatic exp_t ref_of(input int id, input logic signed [31:0] x, input int due);
      exp_t e;
      real  rv;
      e.id  = id;
      e.due = due;
      if (x > XMAX) begin
         e.y = 32'sh7FFF_FFFF; e.s = 1'b1; e.tol = 0;
      end else if (x < XMIN) begin
         e.y = 32'sd0; e.s = 1'b0; e.tol = 0;
      end else begin
         rv    = $exp(real'(x) / 16777216.0) * 16777216.0;
         e.y   = $rtoi(rv + 0.5);
         e.s   = 1'b0;
         e.tol = TOL;
      end
      return e;
   endfunction

   function automatic logic signed [31:0] rand_x();
      case ($urandom_range(0, 11))
         0:       return XMAX;
         1:       return XMIN;
         2:       return XMAX + 32'sd1;
         3:       return XMIN - 32'sd1;
         default: return $signed($urandom_range(0, 32'd419430400)) - 32'sd285212672;
      endcase
   endfunction

   // Drive the current requester state, advance the model across the next edge, wait a cycle
   task automatic step();
      int g;
      int idx;
      logic [N-1:0] hs;
      req_valid = want;
      for (int i = 0; i < N; i++) req_x[32*i +: 32] = wx[i];
      if (rst) begin
         pend_m = '0; rspv_m = '0; ptr_m = 0; infl_v = 1'b0;
         sbq.delete();
      end else begin
         hs = rspv_m & rsp_ready;
         g  = -1;
         for (int off = 0; off < N; off++) begin
            idx = (ptr_m + off) % N;
            if (g < 0 && want[idx] && !pend_m[idx]) g = idx;
         end
         rspv_m = rspv_m & ~hs;
         if (infl_v) rspv_m[infl_id] = 1'b1;
         pend_m = pend_m & ~hs;
         infl_v = (g >= 0);
         if (g >= 0) begin
            pend_m[g] = 1'b1;
            infl_id   = g;
            ptr_m     = (g + 1) % N;
            sbq.push_back(ref_of(g, wx[g], cyc + 2));
            if (persist[g]) wx[g] = rand_x();
            else want[g] = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   initial begin : monitor
      logic [N-1:0]       pv;
      logic [31:0]        py [N];
      logic               ps [N];
      logic [N-1:0]       exp_rdy;
      logic signed [31:0] yv;
      exp_t               e;
      int                 k;
      pv = '0;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            pv = '0;
         end else begin
            exp_rdy = ~pend_m;
            chk("req_ready", req_ready, exp_rdy);
            chk("busy", busy, |pend_m);
            chk("rsp_valid", rsp_valid, rspv_m);
            for (int i = 0; i < N; i++) begin
               yv = rsp_y[32*i +: 32];
               if (rsp_valid[i] && (!pv[i] || rsp_ready[i])) begin
                  k = -1;
                  foreach (sbq[j]) if (k < 0 && sbq[j].id == i) k = j;
                  if (k < 0) begin
                     checks++; failures++;
                     $display("FAIL orphan_rsp: requester %0d got y=%0d with no request outstanding", i, yv);
                  end else begin
                     e = sbq[k];
                     sbq.delete(k);
                     chk("latency", cyc, e.due);
                     chk_tol("rsp_y", longint'(yv), longint'(e.y), e.tol);
                     chk("rsp_sat", rsp_sat[i], e.s);
                  end
               end else if (rsp_valid[i] && pv[i]) begin
                  chk("hold_y", rsp_y[32*i +: 32], py[i]);
                  chk("hold_sat", rsp_sat[i], ps[i]);
               end
               pv[i] = rsp_valid[i];
               py[i] = rsp_y[32*i +: 32];
               ps[i] = rsp_sat[i];
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded time bound");
      $fatal(1, "watchdog");
   end

   logic signed [31:0] specials [8];

   initial begin : stim
      for (int i = 0; i < N; i++) wx[i] = '0;
      specials = '{32'sh0700_0000, -32'sd335544320, XMAX, XMAX + 32'sd1,
                   XMIN, XMIN - 32'sd1, 32'sh8000_0000, 32'sh7FFF_FFFF};
      @(negedge clk);
      repeat (3) step();
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_rsp_sat", rsp_sat, 0);
      chk("reset_busy", busy, 0);
      chk("reset_req_ready", req_ready, 4'hF);
      for (int i = 0; i < N; i++) chk("reset_rsp_y", rsp_y[32*i +: 32], 0);
      rst = 1'b0;

      rsp_ready = '1;
      want[0] = 1'b1; wx[0] = 32'sh0100_0000;
      repeat (5) step();

      wx[0] = 32'sd0; wx[1] = -32'sd8388608; wx[2] = 32'sh0080_0000; wx[3] = 32'sh0200_0000;
      want = '1;
      repeat (8) step();

      foreach (specials[s]) begin
         want[2] = 1'b1; wx[2] = specials[s];
         repeat (3) step();
      end

      for (int i = 0; i < N; i++) wx[i] = rand_x();
      persist = '1; want = '1; rsp_ready = 4'b1101;
      repeat (12) step();
      rsp_ready = '1;
      repeat (4) step();
      persist = '0;
      repeat (6) step();

      for (int i = 0; i < N; i++) wx[i] = rand_x();
      want = 4'b1001; persist = 4'b1001;
      repeat (12) step();
      persist = '0;
      repeat (5) step();

      rsp_ready = 4'b1101;
      want[1] = 1'b1; wx[1] = 32'sh0100_0000;
      repeat (4) step();
      want[2] = 1'b1; wx[2] = 32'sh0100_0000;
      step();
      rst = 1'b1;
      #1;
      chk("rst_async_rsp_valid", rsp_valid, 0);
      chk("rst_async_busy", busy, 0);
      chk("rst_async_req_ready", req_ready, 4'hF);
      step();
      step();
      rst = 1'b0;
      rsp_ready = '1;
      want = '0; want[3] = 1'b1; wx[3] = 32'sh0080_0000;
      repeat (6) step();

      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!want[i] && $urandom_range(0, 2) == 0) begin
               want[i] = 1'b1;
               wx[i]   = rand_x();
            end
         end
         rsp_ready = N'($urandom);
         step();
      end

      want = '0; rsp_ready = '1;
      for (int c = 0; c < 40 && (sbq.size() > 0 || pend_m != '0); c++) step();
      step();
      chk("drain_scoreboard", sbq.size(), 0);
      chk("drain_busy", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
